// File: rtl/l2_fifo_path_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_fifo_path_pkg
//  Description : Shared defaults and error-bit indices for the L2 FIFO path.
//  Revision    : 1.0  initial release
// ============================================================================
package l2_fifo_path_pkg;

  // Default geometry and thresholds of the L2 buffering core
  localparam int L2_DW      = 32;
  localparam int L2_DEPTH   = 16;
  localparam int L2_AF_TH   = 12;
  localparam int L2_AE_TH   = 2;
  localparam int L2_TMO_CYC = 1024;

  // Bit positions inside the sticky err vector
  localparam int ERR_W      = 4;
  localparam int ERR_RX_OVF = 0;
  localparam int ERR_RX_UDF = 1;
  localparam int ERR_TX_OVF = 2;
  localparam int ERR_TX_UDF = 3;

endpackage
`default_nettype wire

// File: rtl/l2_sfifo.sv
`default_nettype none
// ============================================================================
//  Module      : l2_sfifo
//  Description : Single synchronous FWFT FIFO on a register array. Depth need
//                not be a power of two; pointers wrap by compare-and-reset.
//                Emits one-cycle overflow/underflow pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module l2_sfifo #(
  parameter int  DW    = 32,
  parameter int  DEPTH = 16,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] lvl,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LW'(DEPTH));
  assign lvl   = lvl_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle write lands in
  assign do_rd = rd & ~empty & ~clr;
  assign do_wr = wr & (~full | (rd & ~empty)) & ~clr;
  assign ovf   = wr & full & ~rd & ~clr;
  assign udf   = rd & empty & ~clr;

  // Next pointer and level state; flush wins over any same-cycle access
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_wr && !do_rd)      lvl_d = lvl_q + LW'(1);
      else if (do_rd && !do_wr) lvl_d = lvl_q - LW'(1);
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  // Storage array; contents beyond the level are never observed
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/l2_fifo_path.sv
`default_nettype none
// ============================================================================
//  Module      : l2_fifo_path
//  Description : L2 buffering core: RX (host->L3) and TX (L3->host) FIFOs,
//                loopback mux, threshold flags, sticky errors, RX watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module l2_fifo_path
  import l2_fifo_path_pkg::*;
#(
  parameter int  DW      = L2_DW,
  parameter int  DEPTH   = L2_DEPTH,
  parameter int  AF_TH   = L2_AF_TH,
  parameter int  AE_TH   = L2_AE_TH,
  parameter int  TMO_CYC = L2_TMO_CYC,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             loop,
  input  logic             tmo_en,
  input  logic             h_wr,
  input  logic [DW-1:0]    h_din,
  output logic             h_full,
  input  logic             h_rd,
  output logic [DW-1:0]    h_dout,
  output logic             h_empty,
  input  logic             l3_rd,
  output logic [DW-1:0]    l3_dout,
  output logic             l3_empty,
  input  logic             l3_wr,
  input  logic [DW-1:0]    l3_din,
  output logic             l3_full,
  output logic [LW-1:0]    rx_lvl,
  output logic [LW-1:0]    tx_lvl,
  output logic             rx_afull,
  output logic             tx_aempty,
  output logic [ERR_W-1:0] err,
  output logic             rx_tmo
);

  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [DW-1:0]    rx_dout, tx_dout;
  logic             rx_empty, tx_empty, rx_full;
  logic             rx_ovf, rx_udf, tx_ovf, tx_udf;
  logic             rx_rd, tx_rd;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rx_tmo_q, rx_tmo_d;
  logic             stall;

  // In loopback the host read port owns the RX head and L3 reads are dead
  assign rx_rd = loop ? h_rd : l3_rd;
  assign tx_rd = ~loop & h_rd;

  l2_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .clr(clr),
    .wr(h_wr), .din(h_din), .rd(rx_rd),
    .dout(rx_dout), .lvl(rx_lvl), .empty(rx_empty), .full(rx_full),
    .ovf(rx_ovf), .udf(rx_udf)
  );

  l2_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .clr(clr),
    .wr(l3_wr), .din(l3_din), .rd(tx_rd),
    .dout(tx_dout), .lvl(tx_lvl), .empty(tx_empty), .full(l3_full),
    .ovf(tx_ovf), .udf(tx_udf)
  );

  assign h_full    = rx_full;
  assign h_dout    = loop ? rx_dout : tx_dout;
  assign h_empty   = loop ? rx_empty : tx_empty;
  assign l3_dout   = rx_dout;
  assign l3_empty  = loop | rx_empty;
  assign rx_afull  = {{(32-LW){1'b0}}, rx_lvl} >= 32'(AF_TH);
  assign tx_aempty = {{(32-LW){1'b0}}, tx_lvl} <= 32'(AE_TH);
  assign err       = err_q;
  assign rx_tmo    = rx_tmo_q;

  // RX is stalled when data waits and nobody pops it
  assign stall = tmo_en & ~rx_empty & ~rx_rd;

  // Sticky error bits and watchdog next state; flush clears everything
  always_comb begin
    err_d    = err_q;
    cnt_d    = cnt_q;
    rx_tmo_d = rx_tmo_q;
    if (clr) begin
      err_d    = '0;
      cnt_d    = '0;
      rx_tmo_d = 1'b0;
    end else begin
      if (rx_ovf) err_d[ERR_RX_OVF] = 1'b1;
      if (rx_udf) err_d[ERR_RX_UDF] = 1'b1;
      if (tx_ovf) err_d[ERR_TX_OVF] = 1'b1;
      if (tx_udf) err_d[ERR_TX_UDF] = 1'b1;
      if (!stall) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(TMO_CYC - 1)) begin
        rx_tmo_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Flag and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= '0;
      cnt_q    <= '0;
      rx_tmo_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rx_tmo_q <= rx_tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_fifo_path.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_fifo_path
//  Description : Scoreboard bench for l2_fifo_path (DEPTH=5, TMO_CYC=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l2_fifo_path;

  localparam int DW      = 32;
  localparam int DEPTH   = 5;
  localparam int AF_TH   = 4;
  localparam int AE_TH   = 1;
  localparam int TMO_CYC = 8;
  localparam int LW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, clr, loop, tmo_en;
  logic          h_wr, h_rd, l3_rd, l3_wr;
  logic [DW-1:0] h_din, l3_din;
  logic          h_full, h_empty, l3_empty, l3_full;
  logic [DW-1:0] h_dout, l3_dout;
  logic [LW-1:0] rx_lvl, tx_lvl;
  logic          rx_afull, tx_aempty, rx_tmo;
  logic [3:0]    err;

  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  l2_fifo_path #(
    .DW(DW), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .loop(loop), .tmo_en(tmo_en),
    .h_wr(h_wr), .h_din(h_din), .h_full(h_full),
    .h_rd(h_rd), .h_dout(h_dout), .h_empty(h_empty),
    .l3_rd(l3_rd), .l3_dout(l3_dout), .l3_empty(l3_empty),
    .l3_wr(l3_wr), .l3_din(l3_din), .l3_full(l3_full),
    .rx_lvl(rx_lvl), .tx_lvl(tx_lvl), .rx_afull(rx_afull), .tx_aempty(tx_aempty),
    .err(err), .rx_tmo(rx_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_wr = 0; h_rd = 0; l3_rd = 0; l3_wr = 0; clr = 0;
  endtask

  initial begin
    rst = 1; clr = 0; loop = 0; tmo_en = 0;
    h_wr = 0; h_rd = 0; l3_rd = 0; l3_wr = 0; h_din = '0; l3_din = '0;
    cyc(); cyc();
    rst = 0;
    cyc();

    // Reset state
    check("rst_h_empty", 32'(h_empty), 1);
    check("rst_l3_empty", 32'(l3_empty), 1);
    check("rst_full", 32'({h_full, l3_full}), 0);
    check("rst_lvls", 32'({rx_lvl, tx_lvl}), 0);
    check("rst_thr", 32'({rx_afull, tx_aempty}), 32'b01);
    check("rst_err", 32'(err), 0);
    check("rst_tmo", 32'(rx_tmo), 0);
    check("rst_douts", h_dout | l3_dout, 0);

    // Fill RX to full, sweeping the almost-full threshold
    for (int i = 1; i <= DEPTH; i++) begin
      h_wr = 1; h_din = 32'(i * 'h11); rx_q.push_back(h_din);
      cyc();
      check("fill_lvl", 32'(rx_lvl), 32'(i));
      check("fill_afull", 32'(rx_afull), 32'(i >= AF_TH));
    end
    check("full_flag", 32'(h_full), 1);
    h_din = 32'h99;
    cyc();
    idle();
    check("ovf_lvl", 32'(rx_lvl), DEPTH);
    check("ovf_err", 32'(err), 32'b0001);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain1_data", l3_dout, rx_q.pop_front());
      l3_rd = 1;
      cyc();
    end
    idle();
    check("drain1_empty", 32'(l3_empty), 1);
    check("drain1_lvl", 32'(rx_lvl), 0);

    // Refill across the wrap point, then push+pop on full
    for (int i = 0; i < DEPTH; i++) begin
      h_wr = 1; h_din = 32'hA0 + 32'(i); rx_q.push_back(h_din);
      cyc();
    end
    h_wr = 1; h_din = 32'h66; l3_rd = 1;
    check("fullpp_head", l3_dout, rx_q.pop_front());
    rx_q.push_back(h_din);
    cyc();
    idle();
    check("fullpp_lvl", 32'(rx_lvl), DEPTH);
    check("fullpp_err", 32'(err), 32'b0001);

    // Pop on empty TX with same-cycle write
    h_rd = 1; l3_wr = 1; l3_din = 32'h77; tx_q.push_back(l3_din);
    cyc();
    idle();
    check("txudf_err", 32'(err), 32'b1001);
    check("txudf_lvl", 32'(tx_lvl), 1);
    check("aempty_lvl1", 32'(tx_aempty), 1);
    l3_wr = 1; l3_din = 32'h78; tx_q.push_back(l3_din);
    cyc();
    idle();
    check("aempty_lvl2", 32'(tx_aempty), 0);
    while (rx_q.size() > 0) begin
      check("drain2_data", l3_dout, rx_q.pop_front());
      l3_rd = 1;
      cyc();
    end
    idle();
    while (tx_q.size() > 0) begin
      check("tx_data", h_dout, tx_q.pop_front());
      h_rd = 1;
      cyc();
    end
    idle();
    check("tx_empty", 32'({h_empty, tx_lvl}), 32'(1 << LW));

    // Loopback
    loop = 1;
    h_wr = 1; h_din = 32'hA5A5A5A5; rx_q.push_back(h_din);
    cyc();
    idle();
    check("loop_dout", h_dout, 32'hA5A5A5A5);
    check("loop_l3_empty", 32'(l3_empty), 1);
    l3_rd = 1; l3_wr = 1; l3_din = 32'hBEEF; tx_q.push_back(l3_din);
    cyc();
    idle();
    check("loop_l3rd_lvls", 32'({rx_lvl, tx_lvl}), 32'((1 << LW) | 1));
    check("loop_pop_data", h_dout, rx_q.pop_front());
    h_rd = 1;
    cyc();
    idle();
    check("loop_h_empty", 32'(h_empty), 1);
    l3_rd = 1;
    cyc();
    idle();
    check("loop_no_udf", 32'(err), 32'b1001);
    loop = 0;
    #1;
    check("unloop_tx", h_dout, tx_q.pop_front());
    h_rd = 1;
    cyc();
    idle();
    check("unloop_tx_lvl", 32'(tx_lvl), 0);

    // Watchdog: pop at the 7th stalled cycle restarts the count
    tmo_en = 1;
    h_wr = 1; h_din = 32'h5A; rx_q.push_back(h_din);
    cyc();
    idle();
    for (int k = 1; k <= 6; k++) cyc();
    h_wr = 1; h_din = 32'h6B; rx_q.push_back(h_din); l3_rd = 1;
    check("wd_pop_data", l3_dout, rx_q.pop_front());
    cyc();
    idle();
    for (int k = 1; k <= TMO_CYC; k++) begin
      check("wd_quiet", 32'(rx_tmo), 0);
      cyc();
    end
    check("wd_fire", 32'(rx_tmo), 1);

    // Flush with same-cycle writes
    l3_wr = 1; l3_din = 32'hC0DE;
    cyc();
    idle();
    clr = 1; h_wr = 1; l3_wr = 1; h_din = 32'h1; l3_din = 32'h2;
    cyc();
    idle();
    rx_q.delete(); tx_q.delete();
    check("clr_lvls", 32'({rx_lvl, tx_lvl}), 0);
    check("clr_err", 32'(err), 0);
    check("clr_tmo", 32'(rx_tmo), 0);
    check("clr_empty", 32'({h_empty, l3_empty}), 32'b11);
    check("clr_douts", h_dout | l3_dout, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
